// File: rtl/mvm_seq_ctrl.sv
// Sequencing controller for the matrix-vector multiply unit: command decode,
// operand load/read addressing, MAC pipeline control and result streaming.
module mvm_seq_ctrl #(
  parameter int unsigned M    = 12,
  parameter int unsigned PIPE = 2,
  localparam int unsigned MM  = M * M,
  localparam int unsigned AW  = $clog2(M * M),
  localparam int unsigned VW  = $clog2(M)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          loadMatrix,
  input  logic          loadVector,
  input  logic          start,
  output logic          busy,
  output logic          mat_we,
  output logic [AW-1:0] mat_addr,
  output logic          vec_we,
  output logic [VW-1:0] vec_addr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          yb_we,
  output logic [VW-1:0] yb_waddr,
  output logic [VW-1:0] yb_raddr,
  output logic          done
);

  localparam int unsigned DW = $clog2(PIPE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_M, S_LOAD_V, S_COMPUTE, S_DRAIN, S_DONE, S_OUTPUT
  } state_t;

  state_t        r_state, w_state;
  logic          r_busy, w_busy;
  logic          r_mat_we, w_mat_we;
  logic [AW-1:0] r_mat_addr, w_mat_addr;
  logic          r_vec_we, w_vec_we;
  logic [VW-1:0] r_vec_addr, w_vec_addr;
  logic          r_iss_valid, w_iss_valid;
  logic          r_iss_first, w_iss_first;
  logic          r_iss_last, w_iss_last;
  logic [DW-1:0] r_drain, w_drain;
  logic          r_done, w_done;
  logic [VW-1:0] r_raddr, w_raddr;
  logic [VW-1:0] w_col_nxt;

  // Issue flags delayed to the accumulator update cycle
  logic [PIPE-1:0] r_dv, r_df, r_dl;
  logic            r_yb_we;
  logic [VW-1:0]   r_yb_waddr;
  logic [VW-1:0]   r_wrow;

  // State and registered control outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_mat_we    <= 1'b0;
      r_mat_addr  <= '0;
      r_vec_we    <= 1'b0;
      r_vec_addr  <= '0;
      r_iss_valid <= 1'b0;
      r_iss_first <= 1'b0;
      r_iss_last  <= 1'b0;
      r_drain     <= '0;
      r_done      <= 1'b0;
      r_raddr     <= '0;
    end else begin
      r_state     <= w_state;
      r_busy      <= w_busy;
      r_mat_we    <= w_mat_we;
      r_mat_addr  <= w_mat_addr;
      r_vec_we    <= w_vec_we;
      r_vec_addr  <= w_vec_addr;
      r_iss_valid <= w_iss_valid;
      r_iss_first <= w_iss_first;
      r_iss_last  <= w_iss_last;
      r_drain     <= w_drain;
      r_done      <= w_done;
      r_raddr     <= w_raddr;
    end
  end

  // Next-state and next-output decode; addresses fall back to 0 outside their state
  always_comb begin
    w_state     = r_state;
    w_mat_we    = 1'b0;
    w_mat_addr  = '0;
    w_vec_we    = 1'b0;
    w_vec_addr  = '0;
    w_iss_valid = 1'b0;
    w_iss_first = 1'b0;
    w_iss_last  = 1'b0;
    w_drain     = '0;
    w_done      = 1'b0;
    w_raddr     = '0;
    w_col_nxt   = (r_vec_addr == VW'(M - 1)) ? '0 : r_vec_addr + VW'(1);
    case (r_state)
      S_IDLE: begin
        if (loadMatrix) begin
          w_state  = S_LOAD_M;
          w_mat_we = 1'b1;
        end else if (loadVector) begin
          w_state  = S_LOAD_V;
          w_vec_we = 1'b1;
        end else if (start) begin
          w_state     = S_COMPUTE;
          w_iss_valid = 1'b1;
          w_iss_first = 1'b1;
        end
      end
      S_LOAD_M: begin
        if (r_mat_addr == AW'(MM - 1)) begin
          w_state = S_IDLE;
        end else begin
          w_mat_we   = 1'b1;
          w_mat_addr = r_mat_addr + AW'(1);
        end
      end
      S_LOAD_V: begin
        if (r_vec_addr == VW'(M - 1)) begin
          w_state = S_IDLE;
        end else begin
          w_vec_we   = 1'b1;
          w_vec_addr = r_vec_addr + VW'(1);
        end
      end
      S_COMPUTE: begin
        if (r_mat_addr == AW'(MM - 1)) begin
          w_state = S_DRAIN;
        end else begin
          w_mat_addr  = r_mat_addr + AW'(1);
          w_vec_addr  = w_col_nxt;
          w_iss_valid = 1'b1;
          w_iss_first = (w_col_nxt == '0);
          w_iss_last  = (w_col_nxt == VW'(M - 1));
        end
      end
      S_DRAIN: begin
        if (r_drain == DW'(PIPE)) begin
          w_state = S_DONE;
          w_done  = 1'b1;
        end else begin
          w_drain = r_drain + DW'(1);
        end
      end
      S_DONE: begin
        w_state = S_OUTPUT;
        w_raddr = VW'(1);
      end
      S_OUTPUT: begin
        if (r_raddr == VW'(M - 1)) begin
          w_state = S_IDLE;
        end else begin
          w_raddr = r_raddr + VW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state != S_IDLE);
  end

  // MAC pipeline alignment and result-buffer write sequencing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dv       <= '0;
      r_df       <= '0;
      r_dl       <= '0;
      r_yb_we    <= 1'b0;
      r_yb_waddr <= '0;
      r_wrow     <= '0;
    end else begin
      r_dv[0] <= r_iss_valid;
      r_df[0] <= r_iss_first;
      r_dl[0] <= r_iss_last;
      for (int i = 1; i < int'(PIPE); i++) begin
        r_dv[i] <= r_dv[i-1];
        r_df[i] <= r_df[i-1];
        r_dl[i] <= r_dl[i-1];
      end
      r_yb_we <= r_dl[PIPE-1];
      if (r_dl[PIPE-1]) begin
        r_yb_waddr <= r_wrow;
        r_wrow     <= (r_wrow == VW'(M - 1)) ? '0 : r_wrow + VW'(1);
      end
    end
  end

  assign busy     = r_busy;
  assign mat_we   = r_mat_we;
  assign mat_addr = r_mat_addr;
  assign vec_we   = r_vec_we;
  assign vec_addr = r_vec_addr;
  assign acc_en   = r_dv[PIPE-1];
  assign acc_clr  = r_df[PIPE-1];
  assign yb_we    = r_yb_we;
  assign yb_waddr = r_yb_waddr;
  assign yb_raddr = r_raddr;
  assign done     = r_done;

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Directed bench for mvm_seq_ctrl with a behavioural MVM datapath attached.
module tb_mvm_seq_ctrl;
  localparam int unsigned M    = 12;
  localparam int unsigned PIPE = 2;
  localparam int unsigned MM   = M * M;
  localparam int unsigned AW   = $clog2(MM);
  localparam int unsigned VW   = $clog2(M);
  localparam int          ENDC = int'(MM + PIPE + M + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          loadMatrix, loadVector, start;
  logic          busy, mat_we, vec_we, acc_clr, acc_en, yb_we, done;
  logic [AW-1:0] mat_addr;
  logic [VW-1:0] vec_addr, yb_waddr, yb_raddr;
  logic [7:0]    data_in;

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned a_m [MM];
  int unsigned x_v [M];
  int unsigned y_g [M];

  // Datapath model: operand memories, product register, accumulator, result buffer
  logic [7:0]  mem_a [MM];
  logic [7:0]  mem_x [M];
  logic [7:0]  rd_a, rd_x;
  int unsigned prod, acc, data_out;
  int unsigned yb [M];

  mvm_seq_ctrl #(.M(M), .PIPE(PIPE)) dut (
    .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
    .start(start), .busy(busy), .mat_we(mat_we), .mat_addr(mat_addr),
    .vec_we(vec_we), .vec_addr(vec_addr), .acc_clr(acc_clr), .acc_en(acc_en),
    .yb_we(yb_we), .yb_waddr(yb_waddr), .yb_raddr(yb_raddr), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mat_we && int'(mat_addr) < int'(MM)) mem_a[int'(mat_addr)] <= data_in;
    if (vec_we && int'(vec_addr) < int'(M)) mem_x[int'(vec_addr)] <= data_in;
    rd_a <= (int'(mat_addr) < int'(MM)) ? mem_a[int'(mat_addr)] : 8'd0;
    rd_x <= (int'(vec_addr) < int'(M)) ? mem_x[int'(vec_addr)] : 8'd0;
    prod <= 32'(rd_a) * 32'(rd_x);
    if (acc_en) acc <= acc_clr ? prod : acc + prod;
    if (yb_we && int'(yb_waddr) < int'(M)) yb[int'(yb_waddr)] <= acc;
    data_out <= (int'(yb_raddr) < int'(M)) ? yb[int'(yb_raddr)] : 32'd0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] ctl_obs();
    logic [VW-1:0] wa;
    wa = yb_we ? yb_waddr : VW'(0);
    return 64'({busy, mat_we, vec_we, mat_addr, vec_addr, acc_en, acc_clr,
                yb_we, wa, done, yb_raddr});
  endfunction

  function automatic logic [63:0] ctl_exp(input logic e_busy, input logic e_mwe,
      input logic e_vwe, input logic [AW-1:0] e_ma, input logic [VW-1:0] e_va,
      input logic e_en, input logic e_clr, input logic e_ybwe, input logic [VW-1:0] e_wa,
      input logic e_done, input logic [VW-1:0] e_ra);
    return 64'({e_busy, e_mwe, e_vwe, e_ma, e_va, e_en, e_clr, e_ybwe, e_wa, e_done, e_ra});
  endfunction

  task automatic load_matrix();
    for (int k = 0; k < int'(MM); k++) a_m[k] = $urandom_range(0, 255);
    loadMatrix = 1'b1;
    tick();
    loadMatrix = 1'b0;
    for (int k = 0; k < int'(MM); k++) begin
      data_in = 8'(a_m[k]);
      check($sformatf("load_m k=%0d", k), ctl_obs(),
            ctl_exp(1'b1, 1'b1, 1'b0, AW'(k), '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0));
      tick();
    end
    check("load_m end", ctl_obs(), 64'd0);
  endtask

  task automatic load_vector(input bit with_start);
    for (int k = 0; k < int'(M); k++) x_v[k] = $urandom_range(0, 255);
    loadVector = 1'b1;
    start      = with_start;
    tick();
    loadVector = 1'b0;
    start      = 1'b0;
    for (int k = 0; k < int'(M); k++) begin
      data_in = 8'(x_v[k]);
      check($sformatf("load_v k=%0d", k), ctl_obs(),
            ctl_exp(1'b1, 1'b0, 1'b1, '0, VW'(k), 1'b0, 1'b0, 1'b0, '0, 1'b0, '0));
      tick();
    end
    check("load_v end", ctl_obs(), 64'd0);
  endtask

  task automatic golden();
    for (int j = 0; j < int'(M); j++) begin
      y_g[j] = 0;
      for (int c = 0; c < int'(M); c++) y_g[j] += a_m[j * int'(M) + c] * x_v[c];
    end
  endtask

  // Full start..idle sequence; optionally pokes ignored strobes mid-run
  task automatic run_compute(input bit inj);
    logic e_busy, e_en, e_clr, e_ybwe, e_done;
    logic [AW-1:0] e_ma;
    logic [VW-1:0] e_va, e_wa, e_ra;
    golden();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c <= ENDC; c++) begin
      e_busy = (c <= int'(MM + PIPE + M));
      e_ma   = (c < int'(MM)) ? AW'(c) : AW'(0);
      e_va   = (c < int'(MM)) ? VW'(c % int'(M)) : VW'(0);
      e_en   = (c >= int'(PIPE)) && (c < int'(MM + PIPE));
      e_clr  = e_en && ((c - int'(PIPE)) % int'(M) == 0);
      e_ybwe = (c > int'(PIPE)) && (c <= int'(MM + PIPE)) && ((c - int'(PIPE)) % int'(M) == 0);
      e_wa   = e_ybwe ? VW'((c - int'(PIPE)) / int'(M) - 1) : VW'(0);
      e_done = (c == int'(MM + PIPE + 1));
      e_ra   = (c > int'(MM + PIPE + 1) && c <= int'(MM + PIPE + M)) ?
               VW'(c - int'(MM + PIPE + 1)) : VW'(0);
      check($sformatf("compute c=%0d", c), ctl_obs(),
            ctl_exp(e_busy, 1'b0, 1'b0, e_ma, e_va, e_en, e_clr, e_ybwe, e_wa, e_done, e_ra));
      if (c >= int'(MM + PIPE + 2))
        check($sformatf("y[%0d]", c - int'(MM + PIPE + 2)), 64'(data_out),
              64'(y_g[c - int'(MM + PIPE + 2)]));
      if (c < ENDC) begin
        start      = inj && (c == 50);
        loadMatrix = inj && (c == int'(MM + PIPE + 5));
        tick();
        start      = 1'b0;
        loadMatrix = 1'b0;
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    start      = 1'b0;
    data_in    = 8'd0;
    tick();
    tick();
    check("reset outputs", ctl_obs(), 64'd0);
    reset = 1'b1;
    tick();
    check("idle after reset", ctl_obs(), 64'd0);

    // loadMatrix, then loadVector+start on the next edge, then start back-to-back
    load_matrix();
    load_vector(1'b1);
    run_compute(1'b1);

    // Further random operations, all back-to-back
    for (int r = 0; r < 4; r++) begin
      load_matrix();
      load_vector(1'b0);
      run_compute(1'b0);
    end

    // Abort at issue 70 with an asynchronous reset between edges
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (70) tick();
    check("issue 70 addr", 64'(mat_addr), 64'd70);
    #2 reset = 1'b0;
    #1 check("async reset clears", ctl_obs(), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("held reset %0d", i), ctl_obs(), 64'd0);
    end
    reset = 1'b1;
    tick();
    check("idle after abort", ctl_obs(), 64'd0);
    run_compute(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
